// File: rtl/ram_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_copy_ctrl
// Purpose : Pipelined RAM-to-RAM word copier driving a registered-read,
//           negedge-write RAM. Optional fill mode under RAM_COPY_FILL_EN.
// Revision: 1.0  initial release
// ============================================================================
module ram_copy_ctrl #(
    parameter int WORDSIZE = 16,
    parameter int ADDRSIZE = 5,
    parameter int LENSIZE  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDRSIZE-1:0] src_addr,
    input  logic [ADDRSIZE-1:0] dst_addr,
    input  logic [LENSIZE-1:0]  length,
    output logic                busy,
    output logic                done,
    output logic [ADDRSIZE-1:0] read_addr,
    output logic [ADDRSIZE-1:0] write_addr,
    output logic                rd_en,
    output logic                wr_en,
    output logic                cs,
    output logic [WORDSIZE-1:0] ram_wdata,
    input  logic [WORDSIZE-1:0] ram_rdata
`ifdef RAM_COPY_FILL_EN
    ,
    input  logic                fill_mode,
    input  logic [WORDSIZE-1:0] fill_value
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDRSIZE-1:0] c_ADDR_ONE = ADDRSIZE'(1);
    localparam logic [LENSIZE-1:0]  c_LEN_ONE  = LENSIZE'(1);

    state_t                r_state, w_state;
    logic [ADDRSIZE-1:0]   r_read_addr, w_read_addr;
    logic [ADDRSIZE-1:0]   r_write_addr, w_write_addr;
    logic [ADDRSIZE-1:0]   r_wdst, w_wdst;
    logic [LENSIZE-1:0]    r_left, w_left;
    logic                  r_rd_en, w_rd_en;
    logic                  r_wr_en, w_wr_en;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  r_fill, w_fill;
    logic                  w_start_fill;

`ifdef RAM_COPY_FILL_EN
    logic [WORDSIZE-1:0]   r_fill_value;

    assign w_start_fill = fill_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_fill_value <= '0;
        else if (r_state == S_IDLE && start)
            r_fill_value <= fill_value;
    end

    assign ram_wdata = r_wr_en ? (r_fill ? r_fill_value : ram_rdata) : '0;
`else
    assign w_start_fill = 1'b0;
    assign ram_wdata    = r_wr_en ? ram_rdata : '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_read_addr  <= '0;
            r_write_addr <= '0;
            r_wdst       <= '0;
            r_left       <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fill       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_read_addr  <= w_read_addr;
            r_write_addr <= w_write_addr;
            r_wdst       <= w_wdst;
            r_left       <= w_left;
            r_rd_en      <= w_rd_en;
            r_wr_en      <= w_wr_en;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_fill       <= w_fill;
        end
    end

    // r_left counts reads (or fill writes) still to issue after the current one;
    // r_wdst is the destination of the next write to be scheduled.
    always_comb begin
        w_state      = r_state;
        w_read_addr  = r_read_addr;
        w_write_addr = r_write_addr;
        w_wdst       = r_wdst;
        w_left       = r_left;
        w_rd_en      = 1'b0;
        w_wr_en      = 1'b0;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_fill       = r_fill;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_fill = w_start_fill;
                    if (length == '0) begin
                        w_state = S_DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = S_RUN;
                        w_busy  = 1'b1;
                        w_left  = length - c_LEN_ONE;
                        if (w_start_fill) begin
                            w_wr_en      = 1'b1;
                            w_write_addr = dst_addr;
                            w_wdst       = dst_addr + c_ADDR_ONE;
                        end else begin
                            w_rd_en     = 1'b1;
                            w_read_addr = src_addr;
                            w_wdst      = dst_addr;
                        end
                    end
                end
            end
            S_RUN: begin
                if (r_fill) begin
                    if (r_left != '0) begin
                        w_wr_en      = 1'b1;
                        w_write_addr = r_wdst;
                        w_wdst       = r_wdst + c_ADDR_ONE;
                        w_left       = r_left - c_LEN_ONE;
                    end else begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
                end else begin
                    // The word read this cycle is written next cycle.
                    w_wr_en      = 1'b1;
                    w_write_addr = r_wdst;
                    w_wdst       = r_wdst + c_ADDR_ONE;
                    if (r_left != '0) begin
                        w_rd_en     = 1'b1;
                        w_read_addr = r_read_addr + c_ADDR_ONE;
                        w_left      = r_left - c_LEN_ONE;
                    end else begin
                        w_state = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                w_state = S_DONE;
                w_busy  = 1'b0;
                w_done  = 1'b1;
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign busy       = r_busy;
    assign cs         = r_busy;
    assign done       = r_done;
    assign rd_en      = r_rd_en;
    assign wr_en      = r_wr_en;
    assign read_addr  = r_read_addr;
    assign write_addr = r_write_addr;

endmodule
`default_nettype wire

// File: tb/tb_ram_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_copy_ctrl
// Purpose : Directed vector bench for ram_copy_ctrl with a behavioural RAM.
// Revision: 1.0  initial release
// ============================================================================
module tb_ram_copy_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  src_addr = '0;
    logic [4:0]  dst_addr = '0;
    logic [5:0]  length = '0;
    logic        busy, done, rd_en, wr_en, cs;
    logic [4:0]  read_addr, write_addr;
    logic [15:0] ram_wdata, ram_rdata;
`ifdef RAM_COPY_FILL_EN
    logic        fill_mode = 1'b0;
    logic [15:0] fill_value = '0;
`endif

    always #5 clk = ~clk;

    ram_copy_ctrl #(.WORDSIZE(16), .ADDRSIZE(5), .LENSIZE(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .read_addr  (read_addr),
        .write_addr (write_addr),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .cs         (cs),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
`ifdef RAM_COPY_FILL_EN
        ,
        .fill_mode  (fill_mode),
        .fill_value (fill_value)
`endif
    );

    // Behavioural RAM: registered read on posedge, write on negedge, cs-gated output.
    logic [15:0] mem [32];
    logic [15:0] q = '0;
    logic        init_req = 1'b0;

    always @(posedge clk)
        if (cs && rd_en) q <= mem[read_addr];

    assign ram_rdata = cs ? q : 16'h0000;

    always @(negedge clk or posedge init_req) begin
        if (init_req) begin
            for (int i = 0; i < 32; i++) mem[i] = 16'(i);
        end else if (cs && wr_en) begin
            mem[write_addr] = ram_wdata;
        end
    end

    typedef struct {
        logic [4:0]  src;
        logic [4:0]  dst;
        logic [5:0]  len;
        logic        fill;
        logic [15:0] fval;
        int          ign_a;
        int          ign_b;
        int          exp_busy;
        int          exp_rd;
        int          exp_wr;
        int          exp_done_cyc;
        logic [4:0]  chk_addr;
        logic [15:0] chk_val;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] model [32];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic init_mem();
        init_req = 1'b1;
        #1 init_req = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 16'(i);
    endtask

    // Reference: ascending copy loop, evaluated in order.
    task automatic model_apply(input vec_t v);
        logic [4:0] s, d;
        for (int k = 0; k < int'(v.len); k++) begin
            s = v.src + 5'(k);
            d = v.dst + 5'(k);
            model[d] = v.fill ? v.fval : model[s];
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== model[i]) bad++;
        check(name, 64'(bad), 64'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int nb = 0, nr = 0, nw = 0, nd = 0, dc = -1, cs_bad = 0;
        string tag;
        tag = $sformatf("v%0d", idx);
        init_mem();
        @(negedge clk);
        src_addr = v.src; dst_addr = v.dst; length = v.len; start = 1'b1;
`ifdef RAM_COPY_FILL_EN
        fill_mode = v.fill; fill_value = v.fval;
`endif
        for (int c = 1; c <= int'(v.len) + 8; c++) begin
            @(negedge clk);
            nb += int'(busy); nr += int'(rd_en); nw += int'(wr_en);
            if (cs !== busy) cs_bad++;
            if (done) begin
                nd++;
                if (dc < 0) dc = c;
            end
            if (c == v.ign_a || c == v.ign_b) begin
                // Junk command that must be ignored.
                start = 1'b1; src_addr = 5'd20; dst_addr = 5'd0; length = 6'd2;
            end else begin
                start = 1'b0;
            end
        end
        model_apply(v);
        check({tag, " busy_cycles"}, 64'(nb), 64'(v.exp_busy));
        check({tag, " rd_en_cycles"}, 64'(nr), 64'(v.exp_rd));
        check({tag, " wr_en_cycles"}, 64'(nw), 64'(v.exp_wr));
        check({tag, " done_pulses"}, 64'(nd), 64'd1);
        check({tag, " done_cycle"}, 64'(dc), 64'(v.exp_done_cyc));
        check({tag, " cs_eq_busy"}, 64'(cs_bad), 64'd0);
        check({tag, " chk_word"}, 64'(mem[v.chk_addr]), 64'(v.chk_val));
        check_mem({tag, " mem_image"});
    endtask

    initial begin
        int nd;
        //            src dst len fill fval    ignA ignB busy rd  wr  dcyc chk  val
        vecs.push_back('{5'd0,  5'd16, 6'd4,  1'b0, 16'h0, -1, -1,  5,  4,  4,  6, 5'd19, 16'd3});
        vecs.push_back('{5'd30, 5'd2,  6'd4,  1'b0, 16'h0, -1, -1,  5,  4,  4,  6, 5'd4,  16'd0});
        vecs.push_back('{5'd4,  5'd5,  6'd3,  1'b0, 16'h0, -1, -1,  4,  3,  3,  5, 5'd7,  16'd4});
        vecs.push_back('{5'd3,  5'd9,  6'd0,  1'b0, 16'h0, -1, -1,  0,  0,  0,  1, 5'd9,  16'd9});
        vecs.push_back('{5'd0,  5'd16, 6'd8,  1'b0, 16'h0,  3, 10,  9,  8,  8, 10, 5'd23, 16'd7});
        vecs.push_back('{5'd0,  5'd31, 6'd32, 1'b0, 16'h0, -1, -1, 33, 32, 32, 34, 5'd30, 16'd0});
        vecs.push_back('{5'd0,  5'd8,  6'd40, 1'b0, 16'h0, -1, -1, 41, 40, 40, 42, 5'd20, 16'd4});
`ifdef RAM_COPY_FILL_EN
        vecs.push_back('{5'd0,  5'd10, 6'd3,  1'b1, 16'hA5A5, -1, -1, 3, 0, 3, 4, 5'd11, 16'hA5A5});
`endif

        // Reset state while rst is held from time zero.
        #1;
        check("reset_outputs", 64'({busy, done, rd_en, wr_en, cs, read_addr, write_addr, ram_wdata}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Asynchronous reset in the middle of a copy.
        init_mem();
        @(negedge clk);
        src_addr = 5'd0; dst_addr = 5'd16; length = 6'd8; start = 1'b1;
`ifdef RAM_COPY_FILL_EN
        fill_mode = 1'b0;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'({busy, done, rd_en, wr_en, cs, read_addr, write_addr, ram_wdata}), 64'd0);
        check("written_before_reset", 64'(mem[18]), 64'd2);
        check("unwritten_after_reset", 64'(mem[19]), 64'd19);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            nd += int'(done);
        end
        check("no_done_after_abort", 64'(nd), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
